// File: rtl/sp_ram_fill_pkg.sv
// Shared types and the pattern function for the RAM fill/check engine.
// Define RAM_FILL_LFSR_EN to switch the pattern from seed+k to a Galois LFSR sequence.
package sp_ram_fill_pkg;

  typedef enum logic [1:0] {
    MODE_FILL       = 2'd0,
    MODE_CHECK      = 2'd1,
    MODE_FILL_CHECK = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Returns pattern(k) given cur = pattern(k-1); k == 0 restarts from the seed.
  function automatic logic [31:0] next_pattern(input logic [31:0] cur,
                                               input logic [31:0] seed,
                                               input logic [31:0] k);
`ifdef RAM_FILL_LFSR_EN
    if (k == 32'd0) return (seed == 32'd0) ? 32'h1 : seed;
    return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
`else
    if (k == 32'd0) return seed;
    return cur + 32'd1;
`endif
  endfunction

endpackage

// File: rtl/sp_ram_pattern_gen.sv
// Pattern register: load restarts the sequence from the seed, advance steps to the next word.
// Sequence selection follows RAM_FILL_LFSR_EN through the package function.
module sp_ram_pattern_gen
  import sp_ram_fill_pkg::*;
(
  input  logic        clk,
  input  logic        rst_i,
  input  logic        i_load,
  input  logic        i_adv,
  input  logic [31:0] i_seed,
  output logic [31:0] o_pat
);

  logic [31:0] r_pat;

  always_ff @(posedge clk) begin
    if (rst_i)       r_pat <= '0;
    else if (i_load) r_pat <= next_pattern(r_pat, i_seed, 32'd0);
    else if (i_adv)  r_pat <= next_pattern(r_pat, i_seed, 32'd1);
  end

  assign o_pat = r_pat;

endmodule

// File: rtl/sp_ram_fill_check.sv
// Single-port RAM fill / read-back-compare engine; owns the RAM port while busy_o is high.
// Pattern is seed+k by default, Galois LFSR when RAM_FILL_LFSR_EN is defined.
module sp_ram_fill_check
  import sp_ram_fill_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int CNT_WIDTH  = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  input  logic [31:0]           seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  state_e                r_state, w_state_nx;
  mode_e                 r_mode, w_mode_in;
  logic [31:0]           r_seed, w_seed;
  logic [ADDR_WIDTH-1:0] r_base, w_base_al;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_idx, w_idx_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic                  r_en, w_en_nx;
  logic                  r_we, w_we_nx;
  logic [3:0]            r_be;
  logic                  r_busy, r_done;
  logic                  w_start, w_last;
  logic                  w_wload, w_wadv, w_eload, w_eadv;
  logic [31:0]           w_wpat, w_epat;

  logic                  r_cmp_vld;
  logic [31:0]           r_cmp_exp;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err;

  assign w_start   = (r_state == S_IDLE) && start_i;
  assign w_last    = (r_idx == r_cnt - CNT_WIDTH'(1));
  assign w_base_al = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_mode_in = (mode_i == 2'd3) ? MODE_FILL : mode_e'(mode_i);
  // Generators load in the same edge that latches the seed, so bypass the latch in IDLE.
  assign w_seed    = (r_state == S_IDLE) ? seed_i : r_seed;

  sp_ram_pattern_gen u_wgen (
    .clk    (clk),
    .rst_i  (rst_i),
    .i_load (w_wload),
    .i_adv  (w_wadv),
    .i_seed (w_seed),
    .o_pat  (w_wpat)
  );

  sp_ram_pattern_gen u_egen (
    .clk    (clk),
    .rst_i  (rst_i),
    .i_load (w_eload),
    .i_adv  (w_eadv),
    .i_seed (w_seed),
    .o_pat  (w_epat)
  );

  always_ff @(posedge clk) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic also computes the strobe the RAM sees during the next cycle.
  always_comb begin
    w_state_nx = r_state;
    w_en_nx    = 1'b0;
    w_we_nx    = 1'b0;
    w_addr_nx  = r_addr;
    w_idx_nx   = r_idx;
    w_wload    = 1'b0;
    w_wadv     = 1'b0;
    w_eload    = 1'b0;
    w_eadv     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_idx_nx  = '0;
          w_addr_nx = w_base_al;
          if (num_words_i == '0) begin
            w_state_nx = S_DONE;
          end else if (w_mode_in == MODE_CHECK) begin
            w_state_nx = S_READ;
            w_en_nx    = 1'b1;
            w_eload    = 1'b1;
          end else begin
            w_state_nx = S_FILL;
            w_en_nx    = 1'b1;
            w_we_nx    = 1'b1;
            w_wload    = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (w_last) begin
          if (r_mode == MODE_FILL_CHECK) begin
            w_state_nx = S_READ;
            w_en_nx    = 1'b1;
            w_addr_nx  = r_base;
            w_idx_nx   = '0;
            w_eload    = 1'b1;
          end else begin
            w_state_nx = S_DONE;
          end
        end else begin
          w_en_nx   = 1'b1;
          w_we_nx   = 1'b1;
          w_addr_nx = r_addr + ADDR_WIDTH'(4);
          w_idx_nx  = r_idx + CNT_WIDTH'(1);
          w_wadv    = 1'b1;
        end
      end
      S_READ: begin
        if (w_last) begin
          w_state_nx = S_DRAIN;
        end else begin
          w_en_nx   = 1'b1;
          w_addr_nx = r_addr + ADDR_WIDTH'(4);
          w_idx_nx  = r_idx + CNT_WIDTH'(1);
          w_eadv    = 1'b1;
        end
      end
      S_DRAIN: w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_mode <= MODE_FILL;
      r_seed <= '0;
      r_base <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_addr <= '0;
      r_en   <= 1'b0;
      r_we   <= 1'b0;
      r_be   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_mode <= w_mode_in;
        r_seed <= seed_i;
        r_base <= w_base_al;
        r_cnt  <= num_words_i;
      end
      r_idx  <= w_idx_nx;
      r_addr <= w_addr_nx;
      r_en   <= w_en_nx;
      r_we   <= w_we_nx;
      r_be   <= w_we_nx ? 4'hF : 4'h0;
      r_busy <= (w_state_nx != S_IDLE);
      r_done <= (w_state_nx == S_DONE);
    end
  end

  // Read data lands one cycle after the strobe; carry expected word and address alongside.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_exp  <= '0;
      r_cmp_addr <= '0;
    end else begin
      r_cmp_vld  <= r_en && !r_we;
      r_cmp_exp  <= w_epat;
      r_cmp_addr <= r_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_start) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (r_cmp_vld && (ram_rdata_i != r_cmp_exp)) begin
      if (r_err_cnt == '0) r_first_err <= r_cmp_addr;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
    end
  end

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err;
  assign ram_en_o         = r_en;
  assign ram_addr_o       = r_addr;
  assign ram_wdata_o      = w_wpat;
  assign ram_we_o         = r_we;
  assign ram_be_o         = r_be;

endmodule

// File: tb/tb_sp_ram_fill_check.sv
// Directed bench for sp_ram_fill_check with a behavioural single-port RAM (default pattern build).
module tb_sp_ram_fill_check;

  localparam int RS = 32768;
  localparam int AW = 15;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] num_words_i = '0;
  logic [31:0]   seed_i = '0;
  logic          busy_o, done_o, ram_en_o, ram_we_o;
  logic [CW-1:0] err_cnt_o;
  logic [AW-1:0] first_err_addr_o, ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_rdata = '0;

  bit [31:0]     mem [RS/4];
  int            en_cnt = 0;
  logic          inj_req = 1'b0;
  int            inj_idx = 0;
  logic [31:0]   inj_val = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_ram_fill_check dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .mode_i           (mode_i),
    .base_addr_i      (base_addr_i),
    .num_words_i      (num_words_i),
    .seed_i           (seed_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o),
    .ram_en_o         (ram_en_o),
    .ram_addr_o       (ram_addr_o),
    .ram_wdata_o      (ram_wdata_o),
    .ram_we_o         (ram_we_o),
    .ram_be_o         (ram_be_o),
    .ram_rdata_i      (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en_o) begin
      en_cnt <= en_cnt + 1;
      if (ram_we_o) mem[ram_addr_o[AW-1:2]] <= ram_wdata_o;
      else          ram_rdata <= mem[ram_addr_o[AW-1:2]];
    end
    if (inj_req) mem[inj_idx] <= inj_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] m, input logic [AW-1:0] b, input logic [CW-1:0] n,
                        input logic [31:0] s, output int busy_n, output int done_n);
    mode_i = m; base_addr_i = b; num_words_i = n; seed_i = s; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    busy_n = 0;
    done_n = 0;
    while (busy_o && busy_n < 200) begin
      busy_n++;
      if (done_o) done_n++;
      tick();
    end
    check("op_terminates", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int bn, dn, c0;
    logic [AW-1:0] wa [4];

    // reset
    tick(); tick();
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_en", {31'd0, ram_en_o}, 0);
    check("rst_we", {31'd0, ram_we_o}, 0);
    check("rst_be", {28'd0, ram_be_o}, 0);
    check("rst_addr", {17'd0, ram_addr_o}, 0);
    check("rst_wdata", ram_wdata_o, 0);
    check("rst_err", {18'd0, err_cnt_o}, 0);
    check("rst_first", {17'd0, first_err_addr_o}, 0);
    rst_i = 1'b0;
    tick();

    // fill: base 0x100, n=4, seed 0xA0; a start mid-run must be ignored
    mode_i = 2'd0; base_addr_i = 15'h100; num_words_i = 14'd4; seed_i = 32'hA0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("fill_en", {31'd0, ram_en_o}, 1);
      check("fill_we", {31'd0, ram_we_o}, 1);
      check("fill_be", {28'd0, ram_be_o}, 32'hF);
      check("fill_addr", {17'd0, ram_addr_o}, 32'h100 + 32'(4 * k));
      check("fill_data", ram_wdata_o, 32'hA0 + 32'(k));
      check("fill_done_low", {31'd0, done_o}, 0);
      if (k == 1) begin
        start_i = 1'b1; mode_i = 2'd1; base_addr_i = 15'h40; num_words_i = 14'd9;
      end else begin
        start_i = 1'b0;
      end
      tick();
    end
    start_i = 1'b0;
    check("fill_done", {31'd0, done_o}, 1);
    check("fill_done_busy", {31'd0, busy_o}, 1);
    check("fill_done_en", {31'd0, ram_en_o}, 0);
    tick();
    check("fill_after_done", {31'd0, done_o}, 0);
    check("fill_idle_busy", {31'd0, busy_o}, 0);
    c0 = en_cnt;
    tick(); tick();
    check("busy_start_ignored", 32'(en_cnt - c0), 0);
    check("fill_mem_10c", mem[15'h10C >> 2], 32'hA3);

    // fill+check, n=16, seed 0
    run_op(2'd2, 15'h0, 14'd16, 32'd0, bn, dn);
    check("fc_busy_cycles", 32'(bn), 34);
    check("fc_done_cnt", 32'(dn), 1);
    check("fc_err", {18'd0, err_cnt_o}, 0);
    check("fc_first", {17'd0, first_err_addr_o}, 0);
    check("fc_mem5", mem[5], 5);
    check("fc_mem15", mem[15], 15);

    // corrupt word at 0x008, then check only
    inj_idx = 2; inj_val = 32'hDEAD; inj_req = 1'b1;
    tick();
    inj_req = 1'b0;
    run_op(2'd1, 15'h0, 14'd8, 32'd0, bn, dn);
    check("inj_busy_cycles", 32'(bn), 10);
    check("inj_done_cnt", 32'(dn), 1);
    check("inj_err", {18'd0, err_cnt_o}, 1);
    check("inj_first", {17'd0, first_err_addr_o}, 32'h8);

    // wrong seed: every word mismatches, first error at base
    run_op(2'd1, 15'h0, 14'd4, 32'd5, bn, dn);
    check("seed_err", {18'd0, err_cnt_o}, 4);
    check("seed_first", {17'd0, first_err_addr_o}, 0);

    // base 4, seed 1: only 0x008 differs
    run_op(2'd1, 15'h4, 14'd4, 32'd1, bn, dn);
    check("off_err", {18'd0, err_cnt_o}, 1);
    check("off_first", {17'd0, first_err_addr_o}, 32'h8);

    // address wrap, mode 3 behaves as fill
    wa[0] = 15'h7FF8; wa[1] = 15'h7FFC; wa[2] = 15'h0000; wa[3] = 15'h0004;
    mode_i = 2'd3; base_addr_i = 15'h7FF8; num_words_i = 14'd4; seed_i = 32'h55; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wrap_addr", {17'd0, ram_addr_o}, {17'd0, wa[k]});
      check("wrap_we", {31'd0, ram_we_o}, 1);
      check("wrap_data", ram_wdata_o, 32'h55 + 32'(k));
      tick();
    end
    check("wrap_done", {31'd0, done_o}, 1);
    tick();
    check("wrap_mem0", mem[0], 32'h57);
    check("wrap_mem_top", mem[RS/4 - 2], 32'h55);
    run_op(2'd1, 15'h7FF8, 14'd4, 32'h55, bn, dn);
    check("wrap_chk_err", {18'd0, err_cnt_o}, 0);

    // zero-length request
    c0 = en_cnt;
    mode_i = 2'd2; base_addr_i = 15'h80; num_words_i = 14'd0; seed_i = 32'h9; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("n0_done", {31'd0, done_o}, 1);
    check("n0_busy", {31'd0, busy_o}, 1);
    check("n0_en", {31'd0, ram_en_o}, 0);
    tick();
    check("n0_done_end", {31'd0, done_o}, 0);
    check("n0_idle", {31'd0, busy_o}, 0);
    check("n0_no_access", 32'(en_cnt - c0), 0);

    // reset mid-fill after three writes
    c0 = en_cnt;
    mode_i = 2'd0; base_addr_i = 15'h200; num_words_i = 14'd8; seed_i = 32'h10; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    check("mid_wdata", ram_wdata_o, 32'h12);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_en", {31'd0, ram_en_o}, 0);
    check("abort_busy", {31'd0, busy_o}, 0);
    check("abort_done", {31'd0, done_o}, 0);
    tick();
    check("abort_no_done", {31'd0, done_o}, 0);
    check("abort_strobes", 32'(en_cnt - c0), 3);
    check("abort_mem_208", mem[15'h208 >> 2], 32'h12);
    check("abort_mem_20c", mem[15'h20C >> 2], 32'h0);

    // clean run after abort
    run_op(2'd2, 15'h200, 14'd4, 32'h30, bn, dn);
    check("post_busy_cycles", 32'(bn), 10);
    check("post_done_cnt", 32'(dn), 1);
    check("post_err", {18'd0, err_cnt_o}, 0);
    check("post_mem_20c", mem[15'h20C >> 2], 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
